// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: opcode encoding and data width.
// Opcode 4'hB (ALU_OP_ROR) is only decoded when ALU_ROR_EN is defined.
package alu_pkg;

  localparam int ALU_W = 16;

  typedef enum logic [3:0] {
    ALU_OP_ADD = 4'h0,
    ALU_OP_SUB = 4'h1,
    ALU_OP_MUL = 4'h2,
    ALU_OP_AND = 4'h3,
    ALU_OP_OR  = 4'h4,
    ALU_OP_XOR = 4'h5,
    ALU_OP_NOR = 4'h6,
    ALU_OP_SLL = 4'h7,
    ALU_OP_SRL = 4'h8,
    ALU_OP_ROL = 4'h9,
    ALU_OP_SWP = 4'hA,
    ALU_OP_ROR = 4'hB
  } alu_op_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit: SLL, SRL, ROL and (with ALU_ROR_EN) ROR.
// Returns 0 for any other opcode.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  alu_op_t          op,
  output logic [ALU_W-1:0] y
);

  logic [4:0]       rot_n;
  logic [ALU_W-1:0] rol_res;
  logic [ALU_W-1:0] ror_res;

  // A shift by 16 yields zero, so rot_n = 0 needs no special case.
  assign rot_n   = {1'b0, b[3:0]};
  assign rol_res = (a << rot_n) | (a >> (5'd16 - rot_n));
  assign ror_res = (a >> rot_n) | (a << (5'd16 - rot_n));

  always_comb begin
    y = '0;
    unique case (op)
      ALU_OP_SLL: y = a << b;
      ALU_OP_SRL: y = a >> b;
      ALU_OP_ROL: y = rol_res;
`ifdef ALU_ROR_EN
      ALU_OP_ROR: y = ror_res;
`endif
      default:    y = '0;
    endcase
  end

`ifndef ALU_ROR_EN
  logic unused_ror;
  assign unused_ror = ^ror_res;
`endif

endmodule

// File: rtl/cpu_alu.sv
// 16-bit execute-stage ALU with one-cycle registered result.
// Define ALU_ROR_EN to enable opcode 4'hB (rotate right); otherwise it is reserved.
module cpu_alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic [3:0]       ctrl,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] y
);

  alu_op_t          op;
  logic [ALU_W-1:0] shift_y;
  logic [ALU_W-1:0] y_next;

  assign op = alu_op_t'(ctrl);

  alu_shifter u_shifter (
    .a  (a),
    .b  (b),
    .op (op),
    .y  (shift_y)
  );

  always_comb begin
    y_next = '0;
    unique case (op)
      ALU_OP_ADD: y_next = a + b;
      ALU_OP_SUB: y_next = a - b;
      ALU_OP_MUL: y_next = a * b;
      ALU_OP_AND: y_next = a & b;
      ALU_OP_OR:  y_next = a | b;
      ALU_OP_XOR: y_next = a ^ b;
      ALU_OP_NOR: y_next = ~(a | b);
      ALU_OP_SLL,
      ALU_OP_SRL,
      ALU_OP_ROL: y_next = shift_y;
`ifdef ALU_ROR_EN
      ALU_OP_ROR: y_next = shift_y;
`endif
      ALU_OP_SWP: y_next = {a[11:8], a[15:12], a[3:0], a[7:4]};
      default:    y_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) y <= '0;
    else         y <= y_next;
  end

endmodule

// File: tb/tb_cpu_alu.sv
// Directed-vector bench for cpu_alu: reset behaviour, every opcode back-to-back,
// shift/rotate boundaries, reserved codes, and reset asserted mid-stream.
module tb_cpu_alu;

  logic        clk;
  logic        resetn;
  logic [3:0]  ctrl;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] y;

  typedef struct {
    logic [3:0]  ctrl;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  int          n_cmp;
  int          n_bad;

  cpu_alu dut (
    .clk    (clk),
    .resetn (resetn),
    .ctrl   (ctrl),
    .a      (a),
    .b      (b),
    .y      (y)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input logic [3:0] c, input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] e, input string nm);
    vec_t v;
    v.ctrl = c; v.a = va; v.b = vb; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm);
    logic [15:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, y=%h", nm, y);
    end else begin
      e = exp_q.pop_front();
      if (y !== e) begin
        n_bad++;
        $display("FAIL %s: y=%h expected=%h", nm, y, e);
      end
    end
  endtask

  // Drive inputs at negedge, clock them in, check the registered result just after the edge.
  task automatic drive(input logic rst_n, input logic [3:0] c, input logic [15:0] va,
                       input logic [15:0] vb, input logic [15:0] e, input string nm);
    @(negedge clk);
    resetn = rst_n; ctrl = c; a = va; b = vb;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(nm);
  endtask

  initial begin
    logic [15:0] ror_exp;
    n_cmp = 0; n_bad = 0;
    resetn = 1'b0; ctrl = 4'h0; a = '0; b = '0;

`ifdef ALU_ROR_EN
    ror_exp = 16'h8001;
`else
    ror_exp = 16'h0000;
`endif

    add_vec(4'h0, 16'h0001, 16'hFFFF, 16'h0000, "add_wrap");
    add_vec(4'h1, 16'h0003, 16'h0005, 16'hFFFE, "sub_borrow");
    add_vec(4'h1, 16'h002A, 16'h0002, 16'h0028, "sub");
    add_vec(4'h2, 16'h0003, 16'h0004, 16'h000C, "mul");
    add_vec(4'h3, 16'h0003, 16'h0004, 16'h0000, "and");
    add_vec(4'h4, 16'h0003, 16'h0004, 16'h0007, "or");
    add_vec(4'h5, 16'h0003, 16'h0004, 16'h0007, "xor");
    add_vec(4'h6, 16'h0003, 16'h0004, 16'hFFF8, "nor");
    add_vec(4'h2, 16'h0100, 16'h0100, 16'h0000, "mul_ovf");
    add_vec(4'h7, 16'h0003, 16'h0004, 16'h0030, "sll");
    add_vec(4'h8, 16'h0003, 16'h0004, 16'h0000, "srl");
    add_vec(4'h9, 16'h0003, 16'h0004, 16'h0030, "rol");
    add_vec(4'h9, 16'h8001, 16'h0001, 16'h0003, "rol_wrap");
    add_vec(4'h7, 16'h0003, 16'd16,   16'h0000, "sll_16");
    add_vec(4'h8, 16'h8000, 16'd16,   16'h0000, "srl_16");
    add_vec(4'h9, 16'h1234, 16'd16,   16'h1234, "rol_16");
    add_vec(4'h7, 16'h0001, 16'd15,   16'h8000, "sll_15");
    add_vec(4'h8, 16'h8000, 16'd15,   16'h0001, "srl_15");
    add_vec(4'h7, 16'hFFFF, 16'h0100, 16'h0000, "sll_big");
    add_vec(4'h9, 16'h0001, 16'd17,   16'h0002, "rol_b17");
    add_vec(4'hA, 16'h1234, 16'hFFFF, 16'h2143, "swp");
    add_vec(4'hF, 16'h1234, 16'h5678, 16'h0000, "rsvd_f");
    add_vec(4'hC, 16'hFFFF, 16'hFFFF, 16'h0000, "rsvd_c");
    add_vec(4'hB, 16'h0003, 16'h0001, ror_exp,  "op_b");
    add_vec(4'h0, 16'h1234, 16'h1111, 16'h2345, "add");
    add_vec(4'h5, 16'hA5A5, 16'hFFFF, 16'h5A5A, "xor2");
    add_vec(4'h6, 16'h0000, 16'h0000, 16'hFFFF, "nor_zero");

    // Reset sequence: ADD operands present while held in reset, then released.
    drive(1'b0, 4'h0, 16'h002A, 16'h002A, 16'h0000, "reset_hold");
    drive(1'b1, 4'h0, 16'h002A, 16'h002A, 16'h0054, "reset_release");

    // Back-to-back table: a new op every cycle.
    for (int i = 0; i < vecs.size(); i++)
      drive(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // Reset mid-stream overrides an op, and the first edge after release produces a result.
    drive(1'b1, 4'hA, 16'hABCD, 16'h0000, 16'hBADC, "pre_rst");
    drive(1'b0, 4'h6, 16'h0000, 16'h0000, 16'h0000, "mid_rst");
    drive(1'b1, 4'h1, 16'h0000, 16'h0001, 16'hFFFF, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
